// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the program/data memory arbiter slice.
// Build option: MEM_ARB_RR_EN selects round-robin arbitration (fixed A-priority otherwise).
package mem_ctrl_pkg;

  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned DATA_W    = 14;
  localparam int unsigned MEM_DEPTH = 1024;

  // Identifies which requester issued an access.
  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  // One entry of the read-response tag pipeline.
  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rsp_tag_t;

  // Round-robin pointer: which requester was granted most recently.
  typedef enum logic {
    LAST_A = 1'b0,
    LAST_B = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mem_arb_ctrl_rr_arb2.sv
// Two-input grant logic for the shared memory port.
// Build option: MEM_ARB_RR_EN builds the last-grant pointer and alternates on
// contention; without it A always wins and no state is kept.
module rr_arb2 (
`ifdef MEM_ARB_RR_EN
  input  logic iclk,
`endif
  input  logic irst,
  input  logic a_req,
  input  logic b_req,
  output logic a_gnt,
  output logic b_gnt
);
  import mem_ctrl_pkg::*;

`ifdef MEM_ARB_RR_EN
  arb_state_t state, state_nxt;

  // Last-grant pointer; B after reset so A wins the first contention.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) state <= LAST_B;
    else      state <= state_nxt;
  end

  // Grants and pointer update; pointer moves only on an actual grant.
  always_comb begin
    a_gnt     = 1'b0;
    b_gnt     = 1'b0;
    state_nxt = state;
    if (!irst) begin
      a_gnt = a_req && (!b_req || state == LAST_B);
      b_gnt = b_req && (!a_req || state == LAST_A);
    end
    if (a_gnt)      state_nxt = LAST_A;
    else if (b_gnt) state_nxt = LAST_B;
  end
`else
  // Fixed priority: B only gets the port when A is not asking.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!irst) begin
      a_gnt = a_req;
      b_gnt = b_req && !a_req;
    end
  end
`endif

endmodule

// File: rtl/mem_arb_ctrl.sv
// Arbiter and sequencer for the single-port 1024 x 14 program/data memory.
// Requesters A (loader/host) and B (core) share the port; each accepted access
// is registered into a command stage, and read data returns two cycles after
// acceptance on the issuing requester's rvalid.
// Build option: MEM_ARB_RR_EN (round-robin vs. fixed A-priority arbitration).
module mem_arb_ctrl #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 14
) (
  input  logic              iclk,
  input  logic              irst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  import mem_ctrl_pkg::*;

  logic              accept;
  logic              sel_b;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  rsp_tag_t          tag_nxt, tag_s1, tag_s2;
  logic [DATA_W-1:0] a_rdata_q, b_rdata_q;

  rr_arb2 u_arb (
`ifdef MEM_ARB_RR_EN
    .iclk  (iclk),
`endif
    .irst  (irst),
    .a_req (a_req),
    .b_req (b_req),
    .a_gnt (a_gnt),
    .b_gnt (b_gnt)
  );

  // Steer the granted requester's access towards the command stage.
  always_comb begin
    accept        = a_gnt || b_gnt;
    sel_b         = b_gnt;
    sel_we        = sel_b ? b_we    : a_we;
    sel_addr      = sel_b ? b_addr  : a_addr;
    sel_wdata     = sel_b ? b_wdata : a_wdata;
    tag_nxt.valid = accept && !sel_we;
    tag_nxt.id    = sel_b ? REQ_B : REQ_A;
  end

  // Command stage; address/data hold on idle cycles, only the enables drop.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      mem_wr_en <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (accept) begin
      mem_wr_en <= sel_we;
      mem_rd_en <= !sel_we;
      mem_addr  <= sel_addr;
      mem_wdata <= sel_wdata;
    end else begin
      mem_wr_en <= 1'b0;
      mem_rd_en <= 1'b0;
    end
  end

  // Read tag pipeline, two deep to match the memory's registered read.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      tag_s1 <= '0;
      tag_s2 <= '0;
    end else begin
      tag_s1 <= tag_nxt;
      tag_s2 <= tag_s1;
    end
  end

  assign a_rvalid = tag_s2.valid && (tag_s2.id == REQ_A);
  assign b_rvalid = tag_s2.valid && (tag_s2.id == REQ_B);

  // Per-requester hold registers so rdata keeps the last returned word.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      if (a_rvalid) a_rdata_q <= mem_rdata;
      if (b_rvalid) b_rdata_q <= mem_rdata;
    end
  end

  // Returned word is visible in the rvalid cycle itself, held afterwards.
  assign a_rdata = a_rvalid ? mem_rdata : a_rdata_q;
  assign b_rdata = b_rvalid ? mem_rdata : b_rdata_q;

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Self-checking bench for mem_arb_ctrl: directed steps followed by random
// traffic, checked against a transaction-level reference model.
module tb_mem_arb_ctrl;
  import mem_ctrl_pkg::*;

  localparam int AW = 10;
  localparam int DW = 14;

  logic          iclk = 1'b0;
  logic          irst;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          mem_wr_en, mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  always #5 iclk = ~iclk;

  mem_arb_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .iclk(iclk), .irst(irst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Physical memory: single-port, synchronous write, registered read.
  logic [DW-1:0] dev_mem [0:1023];
  always @(posedge iclk) begin
    if (mem_wr_en) dev_mem[mem_addr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= dev_mem[mem_addr];
  end

  // Reference model: accesses take effect in acceptance order; a read
  // returns the array contents at acceptance, delivered two cycles later.
  typedef struct {
    int            due;
    bit            id;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t          rq[$];
  logic [DW-1:0] ref_mem [0:1023];
  bit            last_b;
  int            cyc;
  logic          exp_wr, exp_rd;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata, exp_ard, exp_brd;
  bit            ga, gb;
  int            errors = 0;
  int            checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s (cycle %0d): observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: check mid-cycle against the model, then advance it.
  task automatic cycle();
    bit ea, eb;
    #4;
    if (irst) begin
      rq.delete();
      last_b    = 1'b1;
      exp_wr    = 1'b0;
      exp_rd    = 1'b0;
      exp_addr  = '0;
      exp_wdata = '0;
      exp_ard   = '0;
      exp_brd   = '0;
    end
    ga = 1'b0;
    gb = 1'b0;
    if (!irst) begin
      if (a_req && b_req) begin
`ifdef MEM_ARB_RR_EN
        ga = last_b;
        gb = !last_b;
`else
        ga = 1'b1;
`endif
      end else begin
        ga = a_req;
        gb = b_req;
      end
    end
    ea = 1'b0;
    eb = 1'b0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      if (rq[0].id) begin eb = 1'b1; exp_brd = rq[0].data; end
      else          begin ea = 1'b1; exp_ard = rq[0].data; end
      void'(rq.pop_front());
    end
    chk("a_gnt",     32'(a_gnt),     32'(ga));
    chk("b_gnt",     32'(b_gnt),     32'(gb));
    chk("mem_wr_en", 32'(mem_wr_en), 32'(exp_wr));
    chk("mem_rd_en", 32'(mem_rd_en), 32'(exp_rd));
    chk("mem_addr",  32'(mem_addr),  32'(exp_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
    chk("a_rvalid",  32'(a_rvalid),  32'(ea));
    chk("b_rvalid",  32'(b_rvalid),  32'(eb));
    chk("a_rdata",   32'(a_rdata),   32'(exp_ard));
    chk("b_rdata",   32'(b_rdata),   32'(exp_brd));
    @(posedge iclk);
    if (!irst) begin
      exp_wr = 1'b0;
      exp_rd = 1'b0;
      if (ga || gb) begin
        logic          we;
        logic [AW-1:0] ad;
        logic [DW-1:0] wd;
        we = gb ? b_we    : a_we;
        ad = gb ? b_addr  : a_addr;
        wd = gb ? b_wdata : a_wdata;
        exp_wr    = we;
        exp_rd    = !we;
        exp_addr  = ad;
        exp_wdata = wd;
        if (we) ref_mem[ad] = wd;
        else    rq.push_back('{cyc + 2, gb, ref_mem[ad]});
        last_b = gb;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic drive(input bit ar, input bit aw, input int aa, input int ad,
                       input bit br, input bit bw, input int ba, input int bd);
    a_req = ar; a_we = aw; a_addr = AW'(aa); a_wdata = DW'(ad);
    b_req = br; b_we = bw; b_addr = AW'(ba); b_wdata = DW'(bd);
  endtask

  bit            pa, pb;
  bit            pa_we, pb_we;
  logic [AW-1:0] pa_addr, pb_addr;
  logic [DW-1:0] pa_wd, pb_wd;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      dev_mem[i] = '0;
      ref_mem[i] = '0;
    end
    dev_mem[1] = 14'h0011; ref_mem[1] = 14'h0011;
    dev_mem[2] = 14'h0022; ref_mem[2] = 14'h0022;
    cyc = 0;
    irst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge iclk);
    #1;

    // Reset held with requests pending: no grants, all outputs zero.
    drive(1, 0, 5, 0, 1, 0, 6, 0);
    repeat (2) cycle();
    irst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cycle();

    // A writes 0x2A5 to 0x010, then reads it back.
    drive(1, 1, 'h010, 'h2A5, 0, 0, 0, 0); cycle();
    drive(1, 0, 'h010, 0,     0, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) cycle();

    // Continuous contention for six cycles.
    drive(1, 0, 'h020, 0, 1, 0, 'h021, 0);
    repeat (6) cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) cycle();

    // B writes 0x3FFF at the top address, reads it in the next cycle.
    drive(0, 0, 0, 0, 1, 1, 'h3FF, 'h3FFF); cycle();
    drive(0, 0, 0, 0, 1, 0, 'h3FF, 0);      cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) cycle();

    // Read then write of the same address: the read sees the old word.
    drive(1, 0, 'h010, 0,     0, 0, 0, 0); cycle();
    drive(1, 1, 'h010, 'h155, 0, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) cycle();

    // Interleaved reads from both requesters.
    drive(1, 0, 'h001, 0, 0, 0, 0,     0); cycle();
    drive(0, 0, 0,     0, 1, 0, 'h002, 0); cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) cycle();

    // Put the pointer on A, then reset one cycle after a read is accepted.
    drive(1, 0, 'h001, 0, 0, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    irst = 1'b1;
    repeat (2) cycle();
    irst = 1'b0;
    repeat (4) cycle();
    drive(1, 0, 'h002, 0, 1, 0, 'h001, 0);
    repeat (2) cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) cycle();

    // Random traffic over a small address window to provoke hazards.
    pa = 1'b0;
    pb = 1'b0;
    pa_we = 1'b0; pb_we = 1'b0;
    pa_addr = '0; pb_addr = '0;
    pa_wd = '0;   pb_wd = '0;
    for (int n = 0; n < 400; n++) begin
      if (!pa && $urandom_range(0, 3) != 0) begin
        pa = 1'b1;
        pa_we = 1'($urandom_range(0, 1));
        pa_addr = AW'($urandom_range(0, 15));
        pa_wd = DW'($urandom);
      end
      if (!pb && $urandom_range(0, 3) != 0) begin
        pb = 1'b1;
        pb_we = 1'($urandom_range(0, 1));
        pb_addr = AW'($urandom_range(0, 15));
        pb_wd = DW'($urandom);
      end
      drive(pa, pa_we, int'(pa_addr), int'(pa_wd), pb, pb_we, int'(pb_addr), int'(pb_wd));
      cycle();
      if (ga) pa = 1'b0;
      if (gb) pb = 1'b0;
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arb_ctrl.md
Name: mem_arb_ctrl

Overview:
- Two-port arbiter and sequencer in front of the 1024 x 14-bit single-port synchronous program/data memory.
- Requester A (loader/host) and requester B (core fetch/load-store) share the one memory port.
- Each accepted access is registered into a command stage that drives the memory. Read data is steered back to the issuing requester with a valid strobe.
- Fully pipelined: one access per cycle, fixed read latency.

Parameters:
- ADDR_W, 10, memory address width (depth 2**ADDR_W).
- DATA_W, 14, memory word width.

Ports:
- iclk  in  1  clock; all logic on rising edge.
- irst  in  1  reset; asynchronous, active-high.
- a_req  in  1  requester A access request.
- a_we  in  1  A: 1 = write, 0 = read.
- a_addr  in  ADDR_W  A address.
- a_wdata  in  DATA_W  A write data.
- a_gnt  out  1  A request accepted this cycle (combinational).
- a_rvalid  out  1  A read data valid.
- a_rdata  out  DATA_W  A read data.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as A, for requester B.
- mem_wr_en  out  1  memory write enable.
- mem_rd_en  out  1  memory read enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory registered read data.

Behaviour:
- Acceptance is x_req && x_gnt in cycle N. Requester holds req/we/addr/wdata stable until granted. At most one gnt per cycle. gnt is never asserted without req.
- Arbitration:
  - Only one requester active: it is granted the same cycle.
  - Both active: round-robin. Grant the one not granted last. last_gnt updates only on acceptance.
  - Reset value of last_gnt = B, so A wins the first contention.
- Command stage (registered, cycle N+1):
  - mem_addr/mem_wdata = accepted addr/wdata.
  - mem_wr_en = we; mem_rd_en = ~we.
  - Idle cycle: mem_wr_en = mem_rd_en = 0; mem_addr and mem_wdata hold their last value.
- Response stage:
  - Read tag pipeline: valid bit + requester id, 2 deep.
  - Cycle N+2: x_rvalid = 1 for exactly one cycle, x_rdata = mem_rdata. Read latency is 2 cycles from acceptance.
  - Writes produce no response.
- x_rdata holds its last value when rvalid = 0. It is captured from mem_rdata only on that requester's rvalid.
- Back-to-back: one accepted access per cycle sustained, with no bubbles between reads and writes in either order.
- Ordering:
  - Write accepted in N, then read of the same address accepted in N+1: the read returns the new data (write commits at end of N+1, read samples at end of N+2).
  - Read accepted in N, then write of the same address in N+1: the read returns the old data.
- Address wraps naturally at ADDR_W bits; no range checks.
- Reset values:
  - a_gnt, b_gnt = 0 while irst.
  - a_rvalid, b_rvalid = 0.
  - a_rdata, b_rdata = 0.
  - mem_wr_en, mem_rd_en = 0.
  - mem_addr, mem_wdata = 0.
  - tag pipeline cleared; last_gnt = B.
- Reset mid-operation: in-flight reads are dropped, with no rvalid after reset release. A write already in the command stage when irst asserts is not guaranteed to commit.
- No FSM beyond the arbiter pointer. States: LAST_A, LAST_B.
  - LAST_B -> LAST_A on A acceptance.
  - LAST_A -> LAST_B on B acceptance.
  - Otherwise hold.

Optional Feature:
- Macro MEM_ARB_RR_EN.
- Defined: round-robin arbitration as above.
- Undefined: fixed priority, A always wins contention. The last_gnt register is not built. B is granted only when a_req = 0.
- All other behaviour is identical in both builds.

Decomposition:
- Package mem_ctrl_pkg holds:
  - ADDR_W = 10, DATA_W = 14, MEM_DEPTH = 1024.
  - Requester-id type: REQ_A = 0, REQ_B = 1.
  - Response tag struct {valid, id}.
- One sub-module, rr_arb2: two-input round-robin/fixed-priority grant logic plus the last_gnt register.
- Command and response pipelines stay in the top.

Test Plan:
- Reset, then A writes 0x2A5 to address 0x010 and then reads it → mem_wr_en pulses in the cycle after acceptance; a_rvalid appears 2 cycles after read acceptance with a_rdata = 0x2A5; b_rvalid stays 0.
- A and B both request continuously for 6 cycles (RR build) → grants A,B,A,B,A,B. In the fixed-priority build → six A grants, b_gnt = 0.
- B writes 0x3FFF to 0x3FF, then reads 0x3FF in the next cycle → b_rdata = 0x3FFF; confirms write-then-read forwarding order.
- Interleaved reads: A reads 0x001 (preloaded 0x0011), B reads 0x002 (preloaded 0x0022), back-to-back → a_rvalid at N+2 with 0x0011, b_rvalid at N+3 with 0x0022; rvalid never crosses requesters.
- irst asserted 1 cycle after a read is accepted → no rvalid after release; all outputs 0 during reset; the first post-reset contention grants A.
